switchbox_config_loader: RTL and testbench
==========================================

Name: switchbox_config_loader

Overview:
- Upstream configuration stage for the switch box. Loads a configuration frame word-by-word from the bitstream controller over a valid/ready interface and assembles it in a shadow register.
- Commits the whole frame atomically to the active config bus that drives the switch box `config_in`, so the routing multiplexers never see a partially loaded frame.
- One instance sits per switch box tile in the config chain.

Parameters:
- CONFIG_WIDTH, 160, width of the frame and of the config bus (32 muxes × 5 select bits).
- DATA_WIDTH, 8, width of one bitstream word.
- WORDS, ceil(CONFIG_WIDTH/DATA_WIDTH) = 20, data words per frame (derived; not overridable).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a new frame.
- data_in  input  DATA_WIDTH  bitstream word.
- data_valid  input  1  data_in holds a valid word.
- data_ready  output  1  loader accepts a word this cycle.
- config_out  output  CONFIG_WIDTH  active configuration, connected to the switch box `config_in`.
- config_valid  output  1  one-cycle pulse on the cycle config_out updates.
- busy  output  1  high whenever state != IDLE.
- error  output  1  sticky frame-error flag.

Behaviour:
- Reset (asynchronous, nreset=0):
  - state=IDLE, word counter=0, shadow=0.
  - config_out=0 (every mux selects input 0), config_valid=0, data_ready=0, busy=0, error=0.
- States: IDLE, LOAD, CHECK, COMMIT.
- IDLE:
  - data_ready=0.
  - start=1 → LOAD, counter←0, error←0.
  - data_valid without start is ignored.
- LOAD:
  - data_ready=1 for the whole state.
  - A transfer occurs when data_valid && data_ready. Word k (0-based) is written to shadow[k*DATA_WIDTH +: DATA_WIDTH]. Counter increments per transfer.
  - If CONFIG_WIDTH is not a multiple of DATA_WIDTH, the excess upper bits of the last word are discarded.
  - Transfer of the last word (counter = WORDS-1, or the parity word when enabled) → CHECK.
  - No transfer in a cycle: hold; no timeout.
- start while in LOAD, CHECK or COMMIT:
  - Restart: → LOAD, counter←0, error←0.
  - Any word presented in that same cycle is not accepted.
  - The shadow is not cleared; it is overwritten by the new frame.
- CHECK:
  - One cycle, data_ready=0.
  - Pass → COMMIT. Fail → IDLE with error←1; config_out unchanged.
  - Without the optional feature the check always passes.
- COMMIT:
  - One cycle. config_out←shadow, config_valid=1 for exactly this cycle, then → IDLE.
- Latency: last data transfer at edge N → config_out valid after edge N+2; config_valid is high in the cycle after edge N+2. Frame-to-frame minimum is WORDS+3 cycles including the start cycle.
- config_out changes only in COMMIT or on reset. It is never partially updated.
- error stays high until the next start or reset.

Optional Feature:
- Macro: CONFIG_PARITY_EN.
- Defined:
  - LOAD accepts WORDS+1 words; word WORDS is a parity word that is not stored in the shadow.
  - CHECK passes iff parity word == XOR of all WORDS data words (masked to valid bits for the last word).
  - Mismatch sets error and suppresses the commit.
- Undefined:
  - Exactly WORDS words per frame, CHECK always passes, error is tied to 0.

Test Plan:
- Reset mid-LOAD after 7 words → all outputs 0 immediately (asynchronous), state IDLE; a subsequent full frame loads correctly.
- start, then 20 words 0x00..0x13 with data_valid held high → config_out[7:0]=0x00, config_out[159:152]=0x13; config_valid pulses once, 2 cycles after the last transfer.
- Same frame with data_valid toggled 1/0 every cycle → identical config_out; data_ready high throughout LOAD; only cycles with data_valid=1 count.
- start asserted after 10 words, then a full frame of 0xFF → config_out all ones; no config_valid before the second frame completes; the word presented alongside the restart start is not counted.
- CONFIG_PARITY_EN: frame of 0xA5 ×20 with parity word 0x00 → commit. Same frame with parity 0x01 → error=1, config_valid never pulses, config_out keeps its previous value; next start clears error.
- data_valid=1 in IDLE without start for 5 cycles → data_ready=0, counter stays 0, config_out unchanged.

Source files
------------

// File: rtl/switchbox_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : switchbox_config_loader
// Brief    : Assembles a switch box configuration frame word-by-word into a
//            shadow register and commits it atomically to config_out.
//            Optional macro CONFIG_PARITY_EN adds a trailing parity word check.
// Revision : 1.0 - initial release
// ============================================================================
module switchbox_config_loader #(
  parameter int CONFIG_WIDTH = 160,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    error
);

  localparam int WORDS = (CONFIG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
`ifdef CONFIG_PARITY_EN
  localparam int FRAME_WORDS = WORDS + 1;
`else
  localparam int FRAME_WORDS = WORDS;
`endif
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(FRAME_WORDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]                  r_state;
  logic [1:0]                  w_next;
  logic [CNT_W-1:0]            r_count;
  logic [DATA_WIDTH-1:0]       r_shadow [WORDS];
  logic [WORDS*DATA_WIDTH-1:0] w_shadow_flat;
  logic [CONFIG_WIDTH-1:0]     r_config;
  logic                        r_config_valid;
  logic                        w_xfer;
  logic                        w_commit;
  logic                        w_check_ok;
  logic                        w_ready;
  logic                        w_busy;

  // A start in any state wins: the word presented alongside it is dropped.
  assign w_xfer   = w_ready && data_valid && !start;
  assign w_commit = (r_state == S_COMMIT) && !start;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_IDLE;
        S_LOAD:   if (w_xfer && (r_count == c_last_idx)) w_next = S_CHECK;
        S_CHECK:  w_next = w_check_ok ? S_COMMIT : S_IDLE;
        S_COMMIT: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready = (r_state == S_LOAD);
    w_busy  = (r_state != S_IDLE);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)     r_count <= '0;
    else if (start)  r_count <= '0;
    else if (w_xfer) r_count <= r_count + 1'b1;
  end

  // Parity word lands at index WORDS, which no shadow slot matches.
  for (genvar k = 0; k < WORDS; k++) begin : g_word
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)
        r_shadow[k] <= '0;
      else if (w_xfer && (r_count == CNT_W'(k)))
        r_shadow[k] <= data_in;
    end
    assign w_shadow_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_shadow[k];
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_config       <= '0;
      r_config_valid <= 1'b0;
    end else begin
      r_config_valid <= w_commit;
      if (w_commit) r_config <= w_shadow_flat[CONFIG_WIDTH-1:0];
    end
  end

`ifdef CONFIG_PARITY_EN
  localparam int TAIL_BITS = CONFIG_WIDTH - (WORDS - 1) * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] c_tail_mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - TAIL_BITS);

  logic [DATA_WIDTH-1:0] r_parity;
  logic [DATA_WIDTH-1:0] w_word_masked;
  logic                  r_error;

  // Folding the parity word into the running XOR leaves zero on a good frame.
  assign w_word_masked = (r_count == CNT_W'(WORDS - 1)) ? (data_in & c_tail_mask) : data_in;
  assign w_check_ok    = (r_parity == '0);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)     r_parity <= '0;
    else if (start)  r_parity <= '0;
    else if (w_xfer) r_parity <= r_parity ^ w_word_masked;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)                                   r_error <= 1'b0;
    else if (start)                                r_error <= 1'b0;
    else if ((r_state == S_CHECK) && !w_check_ok)  r_error <= 1'b1;
  end

  assign error = r_error;
`else
  assign w_check_ok = 1'b1;
  assign error      = 1'b0;
`endif

  assign data_ready   = w_ready;
  assign busy         = w_busy;
  assign config_out   = r_config;
  assign config_valid = r_config_valid;

endmodule
`default_nettype wire

// File: tb/tb_switchbox_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_switchbox_config_loader
// Brief    : Directed self-checking bench for switchbox_config_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switchbox_config_loader;

  localparam int CW = 160;
  localparam int DW = 8;
  localparam int NW = 20;

  logic          clock;
  logic          nreset;
  logic          start;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [CW-1:0] config_out;
  logic          config_valid;
  logic          busy;
  logic          error;

  int n_pass  = 0;
  int n_total = 0;
  int vc      = 0;

  switchbox_config_loader #(.CONFIG_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .start        (start),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .config_out   (config_out),
    .config_valid (config_valid),
    .busy         (busy),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (config_valid) vc <= vc + 1;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [CW-1:0] frame_exp(input logic [7:0] base, input bit incr);
    logic [CW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*DW +: DW] = incr ? base + 8'(i) : base;
    return r;
  endfunction

  // Sends n data words (plus the parity word in parity builds when n == NW).
  task automatic send_words(input logic [7:0] base, input bit incr, input int n,
                            input logic [7:0] parity, input bit toggle, output bit ready_ok);
    ready_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (toggle) begin
        data_valid = 1'b0;
        data_in    = 8'hEE;
        ready_ok   = ready_ok & data_ready;
        tick();
      end
      data_in    = incr ? base + 8'(i) : base;
      data_valid = 1'b1;
      ready_ok   = ready_ok & data_ready;
      tick();
    end
`ifdef CONFIG_PARITY_EN
    if (n == NW) begin
      data_in    = parity;
      data_valid = 1'b1;
      tick();
    end
`else
    if (parity != 8'h00) data_in = parity;
`endif
    data_valid = 1'b0;
  endtask

  // Called one step after the last transfer edge N.
  task automatic finish_frame(input string tag, input logic [CW-1:0] exp);
    int vc0;
    vc0 = vc;
    check({tag, "_check_ready"}, CW'(data_ready), CW'(0));
    tick();
    check({tag, "_commit_valid"}, CW'(config_valid), CW'(0));
    tick();
    check({tag, "_valid_pulse"}, CW'(config_valid), CW'(1));
    check({tag, "_config"}, config_out, exp);
    check({tag, "_idle_busy"}, CW'(busy), CW'(0));
    tick();
    check({tag, "_valid_once"}, CW'(vc - vc0), CW'(1));
  endtask

  bit ok;
  int vc_save;
  logic [CW-1:0] cfg_save;

  initial begin
    nreset = 1'b0; start = 1'b0; data_in = '0; data_valid = 1'b0;
    #12;
    check("reset_config", config_out, '0);
    check("reset_outs", CW'({config_valid, data_ready, busy, error}), CW'(0));
    tick();
    nreset = 1'b1;
    tick();

    // Incrementing frame, data_valid held high
    pulse_start();
    check("load_ready", CW'(data_ready), CW'(1));
    check("load_busy", CW'(busy), CW'(1));
    send_words(8'h00, 1'b1, NW, 8'h00 ^ 8'h00, 1'b0, ok);
    finish_frame("inc", frame_exp(8'h00, 1'b1));
    check("inc_low_byte", CW'(config_out[7:0]), CW'(8'h00));
    check("inc_high_byte", CW'(config_out[159:152]), CW'(8'h13));

    // Same frame with data_valid toggling
    pulse_start();
    send_words(8'h00, 1'b1, NW, 8'h00, 1'b1, ok);
    check("toggle_ready", CW'(ok), CW'(1));
    finish_frame("toggle", frame_exp(8'h00, 1'b1));

    // Restart after 10 words, then a full 0xFF frame
    pulse_start();
    vc_save = vc;
    send_words(8'h55, 1'b0, 10, 8'h00, 1'b0, ok);
    start = 1'b1; data_in = 8'h3C; data_valid = 1'b1;
    tick();
    start = 1'b0; data_valid = 1'b0;
    send_words(8'hFF, 1'b0, NW - 1, 8'h00, 1'b0, ok);
    check("restart_still_load", CW'(data_ready), CW'(1));
    check("restart_no_valid", CW'(vc - vc_save), CW'(0));
    send_words(8'hFF, 1'b0, 1, 8'h00, 1'b0, ok);
`ifdef CONFIG_PARITY_EN
    data_in = 8'h00; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
`endif
    finish_frame("restart", {CW{1'b1}});

    // Asynchronous reset mid-load after 7 words
    pulse_start();
    send_words(8'h11, 1'b0, 7, 8'h00, 1'b0, ok);
    #2;
    nreset = 1'b0;
    #1;
    check("async_rst_config", config_out, '0);
    check("async_rst_outs", CW'({config_valid, data_ready, busy, error}), CW'(0));
    tick();
    nreset = 1'b1;
    tick();
    pulse_start();
    send_words(8'h80, 1'b1, NW, 8'h00, 1'b0, ok);
    finish_frame("post_rst", frame_exp(8'h80, 1'b1));

    // data_valid in IDLE without start is ignored
    cfg_save = config_out;
    vc_save  = vc;
    ok = 1'b1;
    data_in = 8'h77; data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ok = ok & !data_ready & !busy;
      tick();
    end
    data_valid = 1'b0;
    check("idle_no_ready", CW'(ok), CW'(1));
    check("idle_config_hold", config_out, cfg_save);
    check("idle_no_valid", CW'(vc - vc_save), CW'(0));

`ifdef CONFIG_PARITY_EN
    pulse_start();
    send_words(8'hA5, 1'b0, NW, 8'h00, 1'b0, ok);
    finish_frame("par_good", frame_exp(8'hA5, 1'b0));
    check("par_good_err", CW'(error), CW'(0));

    pulse_start();
    vc_save = vc;
    send_words(8'hA5, 1'b0, NW, 8'h01, 1'b0, ok);
    check("par_bad_check", CW'(data_ready), CW'(0));
    tick();
    check("par_bad_err", CW'(error), CW'(1));
    check("par_bad_idle", CW'(busy), CW'(0));
    tick();
    tick();
    check("par_bad_no_valid", CW'(vc - vc_save), CW'(0));
    check("par_bad_config", config_out, frame_exp(8'hA5, 1'b0));
    check("par_err_sticky", CW'(error), CW'(1));
    pulse_start();
    check("par_err_cleared", CW'(error), CW'(0));
`else
    check("no_parity_err", CW'(error), CW'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
